// File: rtl/mmc_cmd_control_layer_cmd24_if.sv
// ---------------------------------------------------------------------------
// mmc_cmd_control_layer_cmd24_if
//   Bundles the command handshake, the sector-buffer read port and the
//   byte-level MMC transport port of the CMD24 write sequencer.
//
//   Command side : iCMD_START, iCMD_ADDR -> oCMD_END, oCMD_ERROR
//   Buffer side  : oBUFF_REQ, oBUFF_ADDR -> iBUFF_DATA (one cycle later)
//   MMC side     : oMMC_REQ, oMMC_CS, oMMC_DATA -> iMMC_BUSY, iMMC_VALID,
//                  iMMC_DATA
//
//   Modport master is the sequencer; modport slave is the surrounding
//   dispatcher / buffer / transport.  Signal names keep the sequencer's
//   point of view (i = into the sequencer, o = out of it).
// ---------------------------------------------------------------------------
interface mmc_cmd_control_layer_cmd24_if;
  logic        iCMD_START;
  logic [31:0] iCMD_ADDR;
  logic        oCMD_END;
  logic        oCMD_ERROR;

  logic        oBUFF_REQ;
  logic [6:0]  oBUFF_ADDR;
  logic [31:0] iBUFF_DATA;

  logic        oMMC_REQ;
  logic        iMMC_BUSY;
  logic        oMMC_CS;
  logic [7:0]  oMMC_DATA;
  logic        iMMC_VALID;
  logic [7:0]  iMMC_DATA;

  modport master (
    input  iCMD_START, iCMD_ADDR, iBUFF_DATA, iMMC_BUSY, iMMC_VALID, iMMC_DATA,
    output oCMD_END, oCMD_ERROR, oBUFF_REQ, oBUFF_ADDR, oMMC_REQ, oMMC_CS,
           oMMC_DATA
  );

  modport slave (
    output iCMD_START, iCMD_ADDR, iBUFF_DATA, iMMC_BUSY, iMMC_VALID, iMMC_DATA,
    input  oCMD_END, oCMD_ERROR, oBUFF_REQ, oBUFF_ADDR, oMMC_REQ, oMMC_CS,
           oMMC_DATA
  );
endinterface

// File: rtl/mmc_cmd_control_layer_cmd24.sv
// ---------------------------------------------------------------------------
// mmc_cmd_control_layer_cmd24
//   Single-block write (CMD24) sequencer for the SPI-mode MMC/SD command
//   control layer.  A start pulse sends the CMD24 frame, polls R1 until 0x00
//   (bounded by P_R1_RETRY), reads 128 words from the sector buffer and
//   streams them LSB-first as a 0xFE-tokened 512-byte block with a dummy CRC,
//   checks the data-response token and polls busy until the card releases.
//
// Ports
//   iCLOCK       system clock, rising edge
//   iRESET       asynchronous active-high reset
//   iRESET_SYNC  synchronous reset, same effect as iRESET
//   bus          mmc_cmd_control_layer_cmd24_if.master
//                  command handshake, sector-buffer read port, MMC byte port
// ---------------------------------------------------------------------------
module mmc_cmd_control_layer_cmd24 #(
  parameter int unsigned P_R1_RETRY = 8
) (
  input logic                           iCLOCK,
  input logic                           iRESET,
  input logic                           iRESET_SYNC,
  mmc_cmd_control_layer_cmd24_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CMD       = 4'd1,
    ST_RESP_REQ  = 4'd2,
    ST_RESP_GET  = 4'd3,
    ST_GAP       = 4'd4,
    ST_TOKEN     = 4'd5,
    ST_FETCH     = 4'd6,
    ST_LATCH     = 4'd7,
    ST_SEND      = 4'd8,
    ST_CRC       = 4'd9,
    ST_DRESP_REQ = 4'd10,
    ST_DRESP_GET = 4'd11,
    ST_BUSY_REQ  = 4'd12,
    ST_BUSY_GET  = 4'd13,
    ST_END       = 4'd14
  } state_t;

  localparam logic [7:0] R1_LAST = 8'(P_R1_RETRY - 1);

  state_t      state_q;
  logic [9:0]  cnt_q;        // command byte index, data byte index, CRC index
  logic [7:0]  retry_q;      // R1 polls already answered with a non-zero byte
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        cmd_end_q;
  logic        cmd_error_q;
  logic        buff_req_q;
  logic [6:0]  buff_addr_q;
  logic        cs_q;

  logic        tx_state;     // current state wants to transmit a byte
  logic [7:0]  tx_byte;
  logic        accept;       // transport takes the byte this cycle
  logic [9:0]  cnt_inc;

  // ---------------------------------------------------------------------------
  // Transmit decode.  The byte on oMMC_DATA is a pure function of the state
  // and counters; states that define no byte send 0xFF (idle line level).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latch inferred).
    tx_state = 1'b0;
    tx_byte  = 8'hFF;
    case (state_q)
      ST_CMD: begin
        tx_state = 1'b1;
        case (cnt_q[2:0])
          3'd0:    tx_byte = 8'h58;
          3'd1:    tx_byte = addr_q[31:24];
          3'd2:    tx_byte = addr_q[23:16];
          3'd3:    tx_byte = addr_q[15:8];
          3'd4:    tx_byte = addr_q[7:0];
          3'd5:    tx_byte = 8'h01;      // dummy CRC + end bit
          default: tx_byte = 8'hFF;
        endcase
      end
      ST_RESP_REQ, ST_GAP, ST_CRC, ST_DRESP_REQ, ST_BUSY_REQ: tx_state = 1'b1;
      ST_TOKEN: begin
        tx_state = 1'b1;
        tx_byte  = 8'hFE;
      end
      // Least-significant byte first, mirroring the CMD17 receive packing.
      ST_SEND: begin
        tx_state = 1'b1;
        tx_byte  = word_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign accept  = tx_state && !bus.iMMC_BUSY;
  assign cnt_inc = cnt_q + 10'd1;

  assign bus.oMMC_REQ   = accept;
  assign bus.oMMC_DATA  = tx_byte;
  assign bus.oMMC_CS    = cs_q;
  assign bus.oCMD_END   = cmd_end_q;
  assign bus.oCMD_ERROR = cmd_error_q;
  assign bus.oBUFF_REQ  = buff_req_q;
  assign bus.oBUFF_ADDR = buff_addr_q;

  // ---------------------------------------------------------------------------
  // Sequencer.  Registered outputs are updated together with the transition
  // into the state that owns them, so they are valid for that state's cycle.
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      cmd_end_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      buff_req_q  <= 1'b0;
      buff_addr_q <= '0;
      cs_q        <= 1'b1;
    end else if (iRESET_SYNC) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      cmd_end_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      buff_req_q  <= 1'b0;
      buff_addr_q <= '0;
      cs_q        <= 1'b1;
    end else begin
      // Single-cycle pulses.
      cmd_end_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      buff_req_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.iCMD_START) begin
            addr_q  <= bus.iCMD_ADDR;
            cnt_q   <= '0;
            retry_q <= '0;
            cs_q    <= 1'b0;
            state_q <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_q == 10'd5) state_q <= ST_RESP_REQ;
          end
        end

        ST_RESP_REQ: if (accept) state_q <= ST_RESP_GET;

        ST_RESP_GET: begin
          if (bus.iMMC_VALID) begin
            if (bus.iMMC_DATA == 8'h00) begin
              state_q <= ST_GAP;
            end else if (retry_q < R1_LAST) begin
              retry_q <= retry_q + 8'd1;
              state_q <= ST_RESP_REQ;
            end else begin
              err_q       <= 1'b1;
              cmd_end_q   <= 1'b1;
              cmd_error_q <= 1'b1;
              cs_q        <= 1'b1;
              state_q     <= ST_END;
            end
          end
        end

        ST_GAP: if (accept) state_q <= ST_TOKEN;

        ST_TOKEN: begin
          if (accept) begin
            cnt_q       <= '0;
            buff_req_q  <= 1'b1;
            buff_addr_q <= '0;
            state_q     <= ST_FETCH;
          end
        end

        // The buffer answers one cycle after the request.
        ST_FETCH: state_q <= ST_LATCH;

        ST_LATCH: begin
          word_q  <= bus.iBUFF_DATA;
          state_q <= ST_SEND;
        end

        ST_SEND: begin
          if (accept) begin
            if (cnt_inc == 10'd512) begin
              cnt_q   <= '0;
              state_q <= ST_CRC;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc[1:0] == 2'd0) begin
                buff_req_q  <= 1'b1;
                buff_addr_q <= cnt_inc[8:2];
                state_q     <= ST_FETCH;
              end
            end
          end
        end

        ST_CRC: begin
          if (accept) begin
            if (cnt_q[0]) begin
              cnt_q   <= '0;
              state_q <= ST_DRESP_REQ;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        ST_DRESP_REQ: if (accept) state_q <= ST_DRESP_GET;

        // 0xFF means the card has not produced its token yet; keep polling.
        ST_DRESP_GET: begin
          if (bus.iMMC_VALID) begin
            if (bus.iMMC_DATA[4:0] == 5'h05) begin
              state_q <= ST_BUSY_REQ;
            end else if (bus.iMMC_DATA == 8'hFF) begin
              state_q <= ST_DRESP_REQ;
            end else begin
              err_q       <= 1'b1;
              cmd_end_q   <= 1'b1;
              cmd_error_q <= 1'b1;
              cs_q        <= 1'b1;
              state_q     <= ST_END;
            end
          end
        end

        ST_BUSY_REQ: if (accept) state_q <= ST_BUSY_GET;

        // The card holds the line at 0x00 while programming.
        ST_BUSY_GET: begin
          if (bus.iMMC_VALID) begin
            if (bus.iMMC_DATA == 8'h00) begin
              state_q <= ST_BUSY_REQ;
            end else begin
              cmd_end_q   <= 1'b1;
              cmd_error_q <= err_q;
              cs_q        <= 1'b1;
              state_q     <= ST_END;
            end
          end
        end

        ST_END: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          cs_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_cmd_control_layer_cmd24.sv
`timescale 1ns/1ps
module tb_mmc_cmd_control_layer_cmd24;

  localparam int R1_RETRY = 8;

  logic iCLOCK = 1'b0;
  logic iRESET;
  logic iRESET_SYNC;

  mmc_cmd_control_layer_cmd24_if bus();

  mmc_cmd_control_layer_cmd24 #(.P_R1_RETRY(R1_RETRY)) dut (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .bus         (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ------------------------------------------------------------- shared state
  typedef enum {C_CMD, C_R1, C_TOK, C_DATA, C_CRC, C_DRESP, C_BUSY, C_DONE} card_t;

  logic [7:0] exp_q[$];          // expected transmit byte stream
  logic [7:0] r1_q[$];
  logic [7:0] dresp_q[$];
  logic [7:0] busy_q[$];
  card_t      card_ph = C_CMD;
  int         card_cnt = 0;
  int         data_bytes = 0;
  int         bytes_sent = 0;
  int         stall_max = 0;
  int         pat = 0;
  int         exp_buf_addr = 0;
  int         buf_reads = 0;
  int         end_seen = 0;
  logic       end_err = 1'b0;
  int         req_busy_viol = 0;

  function automatic logic [31:0] buf_word(input int k);
    logic [7:0] b;
    b = 8'(k);
    if (pat == 0) return {4{b}};
    return {b ^ 8'h3C, b + 8'd1, ~b, b};
  endfunction

  // Card behaviour: answer each accepted byte according to where the card
  // thinks the protocol is.
  task automatic card_step(input logic [7:0] b, output logic [7:0] rx);
    rx = 8'hFF;
    case (card_ph)
      C_CMD: begin
        card_cnt++;
        if (card_cnt == 6) card_ph = C_R1;
      end
      C_R1: begin
        rx = (r1_q.size() > 0) ? r1_q.pop_front() : 8'h01;
        if (rx == 8'h00) card_ph = C_TOK;
      end
      C_TOK: if (b == 8'hFE) begin card_ph = C_DATA; card_cnt = 0; end
      C_DATA: begin
        card_cnt++;
        data_bytes++;
        if (card_cnt == 512) begin card_ph = C_CRC; card_cnt = 0; end
      end
      C_CRC: begin
        card_cnt++;
        if (card_cnt == 2) card_ph = C_DRESP;
      end
      C_DRESP: begin
        rx = (dresp_q.size() > 0) ? dresp_q.pop_front() : 8'hFF;
        if (rx[4:0] == 5'h05) card_ph = C_BUSY;
        else if (rx != 8'hFF) card_ph = C_DONE;
      end
      C_BUSY: begin
        rx = (busy_q.size() > 0) ? busy_q.pop_front() : 8'hFF;
        if (rx != 8'h00) card_ph = C_DONE;
      end
      default: ;
    endcase
  endtask

  // ---------------------------------------------------------- transport model
  initial begin : transport
    logic       pend;
    logic [7:0] pend_rx;
    logic [7:0] b;
    logic [7:0] rx;
    logic [8:0] exp;
    int         stall_left;
    pend = 1'b0; pend_rx = 8'hFF; stall_left = 0;
    bus.iMMC_BUSY  = 1'b0;
    bus.iMMC_VALID = 1'b0;
    bus.iMMC_DATA  = 8'hFF;
    forever begin
      @(negedge iCLOCK);
      bus.iMMC_VALID = 1'b0;
      if (pend) begin
        if (stall_left > 0) begin
          bus.iMMC_BUSY = 1'b1;
          stall_left--;
          if (stall_left == 0) begin
            bus.iMMC_VALID = 1'b1; bus.iMMC_DATA = pend_rx; pend = 1'b0;
          end
        end else begin
          bus.iMMC_BUSY = 1'b0;
          bus.iMMC_VALID = 1'b1; bus.iMMC_DATA = pend_rx; pend = 1'b0;
        end
      end else begin
        bus.iMMC_BUSY = 1'b0;
      end
      #1;
      if (bus.oMMC_REQ && bus.iMMC_BUSY) req_busy_viol++;
      if (bus.oMMC_REQ && !bus.iMMC_BUSY) begin
        b = bus.oMMC_DATA;
        bytes_sent++;
        exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check("tx_byte", {1'b0, b}, exp);
        card_step(b, rx);
        pend = 1'b1;
        pend_rx = rx;
        stall_left = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
      end
    end
  end

  // ------------------------------------------------------------ sector buffer
  initial begin : sector_buffer
    logic       prev_req;
    logic [6:0] prev_addr;
    prev_req = 1'b0; prev_addr = '0;
    bus.iBUFF_DATA = 32'hDEAD_BEEF;
    forever begin
      @(negedge iCLOCK);
      bus.iBUFF_DATA = prev_req ? buf_word(int'(prev_addr)) : 32'hDEAD_BEEF;
      #1;
      prev_req  = bus.oBUFF_REQ;
      prev_addr = bus.oBUFF_ADDR;
      if (prev_req) begin
        check("buf_addr", {25'd0, prev_addr}, exp_buf_addr);
        exp_buf_addr++;
        buf_reads++;
      end
    end
  end

  // -------------------------------------------------------------- end monitor
  initial begin : end_monitor
    forever begin
      @(negedge iCLOCK);
      #1;
      if (bus.oCMD_END) begin
        end_seen++;
        end_err = bus.oCMD_ERROR;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic start_cmd(input logic [31:0] addr, input int p, input int smax,
                           input int n_r1_ff, input logic r1_fail,
                           input int n_dresp_ff, input logic [7:0] dresp,
                           input int n_busy0);
    logic [31:0] w;
    int n_r1;
    @(negedge iCLOCK);
    pat = p; stall_max = smax;
    exp_q.delete(); r1_q.delete(); dresp_q.delete(); busy_q.delete();
    card_ph = C_CMD; card_cnt = 0; data_bytes = 0; bytes_sent = 0;
    exp_buf_addr = 0; buf_reads = 0; end_seen = 0; req_busy_viol = 0;

    if (r1_fail) repeat (R1_RETRY + 2) r1_q.push_back(8'h01);
    else begin repeat (n_r1_ff) r1_q.push_back(8'hFF); r1_q.push_back(8'h00); end
    repeat (n_dresp_ff) dresp_q.push_back(8'hFF);
    dresp_q.push_back(dresp);
    repeat (n_busy0) busy_q.push_back(8'h00);
    busy_q.push_back(8'hFF);

    exp_q.push_back(8'h58);
    exp_q.push_back(addr[31:24]); exp_q.push_back(addr[23:16]);
    exp_q.push_back(addr[15:8]);  exp_q.push_back(addr[7:0]);
    exp_q.push_back(8'h01);
    n_r1 = r1_fail ? R1_RETRY : n_r1_ff + 1;
    repeat (n_r1) exp_q.push_back(8'hFF);
    if (!r1_fail) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int k = 0; k < 128; k++) begin
        w = buf_word(k);
        for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
      end
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      repeat (n_dresp_ff + 1) exp_q.push_back(8'hFF);
      if (dresp[4:0] == 5'h05) repeat (n_busy0 + 1) exp_q.push_back(8'hFF);
    end

    bus.iCMD_ADDR  = addr;
    bus.iCMD_START = 1'b1;
    @(negedge iCLOCK);
    bus.iCMD_START = 1'b0;
    bus.iCMD_ADDR  = $urandom();
  endtask

  task automatic finish_cmd(input string tag, input logic exp_err, input int exp_reads);
    for (int i = 0; i < 20000 && end_seen == 0; i++) @(negedge iCLOCK);
    repeat (6) @(negedge iCLOCK);
    check({tag, "_end_count"}, end_seen, 1);
    check({tag, "_error"}, {31'd0, end_err}, {31'd0, exp_err});
    check({tag, "_buf_reads"}, buf_reads, exp_reads);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_req_while_busy"}, req_busy_viol, 0);
    check({tag, "_cs_idle"}, {31'd0, bus.oMMC_CS}, 1);
  endtask

  initial begin
    bus.iCMD_START = 1'b0;
    bus.iCMD_ADDR  = '0;
    iRESET = 1'b1;
    iRESET_SYNC = 1'b0;
    repeat (3) @(negedge iCLOCK);
    #1;
    check("rst_cmd_end",   {31'd0, bus.oCMD_END}, 0);
    check("rst_cmd_error", {31'd0, bus.oCMD_ERROR}, 0);
    check("rst_buff_req",  {31'd0, bus.oBUFF_REQ}, 0);
    check("rst_buff_addr", {25'd0, bus.oBUFF_ADDR}, 0);
    check("rst_mmc_req",   {31'd0, bus.oMMC_REQ}, 0);
    check("rst_mmc_cs",    {31'd0, bus.oMMC_CS}, 1);
    check("rst_mmc_data",  {24'd0, bus.oMMC_DATA}, 32'hFF);
    @(negedge iCLOCK);
    iRESET = 1'b0;
    repeat (2) @(negedge iCLOCK);

    // Normal write.
    start_cmd(32'h0000_1200, 0, 0, 0, 1'b0, 0, 8'hE5, 3);
    finish_cmd("normal", 1'b0, 128);

    // R1 busy three times; a start pulse mid-transfer must be ignored.
    start_cmd(32'hDEAD_BEEF, 1, 0, 3, 1'b0, 0, 8'hE5, 1);
    for (int i = 0; i < 5000 && data_bytes < 100; i++) @(negedge iCLOCK);
    bus.iCMD_ADDR = 32'h1234_5678;
    bus.iCMD_START = 1'b1;
    @(negedge iCLOCK);
    bus.iCMD_START = 1'b0;
    finish_cmd("r1_retry", 1'b0, 128);

    // R1 never ready.
    start_cmd(32'h0000_0400, 0, 0, 0, 1'b1, 0, 8'hE5, 0);
    finish_cmd("r1_timeout", 1'b1, 0);

    // Data response not ready twice, then CRC error.
    start_cmd(32'h0008_0000, 1, 0, 0, 1'b0, 2, 8'h0B, 0);
    finish_cmd("dresp_crc_err", 1'b1, 128);

    // Random transport stalls.
    start_cmd(32'h0000_1200, 0, 5, 0, 1'b0, 0, 8'hE5, 3);
    finish_cmd("stalls", 1'b0, 128);

    // Asynchronous reset in the middle of the data block.
    start_cmd(32'h0000_1200, 0, 0, 0, 1'b0, 0, 8'hE5, 3);
    for (int i = 0; i < 5000 && data_bytes < 200; i++) @(negedge iCLOCK);
    check("arst_reached_byte200", {31'd0, data_bytes >= 200}, 1);
    iRESET = 1'b1;
    @(posedge iCLOCK);
    #1;
    check("arst_cs",  {31'd0, bus.oMMC_CS}, 1);
    check("arst_req", {31'd0, bus.oMMC_REQ}, 0);
    @(negedge iCLOCK);
    iRESET = 1'b0;
    repeat (10) @(negedge iCLOCK);
    check("arst_no_end", end_seen, 0);

    start_cmd(32'h0000_1200, 0, 0, 0, 1'b0, 0, 8'hE5, 3);
    finish_cmd("after_arst", 1'b0, 128);

    // Synchronous reset during the command frame.
    start_cmd(32'h0000_3300, 0, 0, 0, 1'b0, 0, 8'hE5, 0);
    for (int i = 0; i < 100 && bytes_sent < 3; i++) @(negedge iCLOCK);
    iRESET_SYNC = 1'b1;
    @(posedge iCLOCK);
    #1;
    check("srst_cs",  {31'd0, bus.oMMC_CS}, 1);
    check("srst_req", {31'd0, bus.oMMC_REQ}, 0);
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    repeat (10) @(negedge iCLOCK);
    check("srst_no_end", end_seen, 0);

    start_cmd(32'h0000_1200, 1, 2, 1, 1'b0, 1, 8'hE5, 2);
    finish_cmd("after_srst", 1'b0, 128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_control_layer_cmd24.md
# mmc_cmd_control_layer_cmd24

Single-block write (CMD24) sequencer for the MMC/SD SPI command control layer. On a start pulse it sends the CMD24 frame, waits for R1 = 0x00, and fetches 128 32-bit words from the sector buffer. It streams those words as a 0xFE-tokened 512-byte data block with a dummy CRC, checks the data-response token, and polls busy until the card releases. It drives the same byte-level MMC transport as the read-side command blocks and reports completion and error to the command dispatcher.

## Interface
- P_R1_RETRY, 8: maximum R1 poll bytes before aborting with error.
- iCLOCK  in  1  system clock, all logic on rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iRESET_SYNC  in  1  synchronous reset; same effect as iRESET.
- iCMD_START  in  1  start pulse; sampled only in IDLE.
- iCMD_ADDR  in  32  card address; latched on accepted start.
- oCMD_END  out  1  one-cycle pulse on completion (success or error).
- oCMD_ERROR  out  1  valid with oCMD_END: 1 = R1 timeout or data rejected.
- oBUFF_REQ  out  1  word read request to the sector buffer.
- oBUFF_ADDR  out  7  word index 0..127.
- iBUFF_DATA  in  32  read data, valid exactly one cycle after oBUFF_REQ.
- oMMC_REQ  out  1  byte transfer request; accepted when oMMC_REQ && !iMMC_BUSY.
- iMMC_BUSY  in  1  transport busy. The transport delivers iMMC_VALID for a byte before it deasserts busy for the next byte.
- oMMC_CS  out  1  chip select, active low.
- oMMC_DATA  out  8  transmit byte.
- iMMC_VALID  in  1  received byte strobe.
- iMMC_DATA  in  8  received byte.

## Operation
- States: IDLE, CMD, RESP_REQ, RESP_GET, GAP, TOKEN, FETCH, LATCH, SEND, CRC, DRESP_REQ, DRESP_GET, BUSY_REQ, BUSY_GET, END.
- IDLE: CS high, oMMC_REQ 0. On iCMD_START, latch the address, clear the byte counter and retry counter, and go to CMD.
- CMD: send bytes 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0x01. The counter advances on each accept. After 6 accepts, go to RESP_REQ.
- RESP_REQ: send 0xFF, then go to RESP_GET.
- RESP_GET: on iMMC_VALID:
  - byte 0x00 → GAP.
  - any other byte with retry count < P_R1_RETRY-1 → increment the retry count and return to RESP_REQ.
  - otherwise → set the error flag and go to END.
- GAP: send 0xFF, then go to TOKEN.
- TOKEN: send 0xFE, clear the byte counter (10-bit), then go to FETCH.
- FETCH: oBUFF_REQ = 1 for one cycle with oBUFF_ADDR = count[8:2], then go to LATCH.
- LATCH: capture iBUFF_DATA into the word register, then go to SEND.
- SEND: transmit word[8*count[1:0]+7 : 8*count[1:0]], so the least-significant byte goes first. This matches the CMD17 receive packing. On each accept, increment count:
  - new count == 512 → clear count and go to CRC.
  - else if new count[1:0] == 0 → FETCH.
- CRC: send 0xFF twice, then go to DRESP_REQ.
- DRESP_REQ: send 0xFF, then go to DRESP_GET.
- DRESP_GET: on iMMC_VALID:
  - (byte & 0x1F) == 0x05 → BUSY_REQ.
  - byte == 0xFF → back to DRESP_REQ; not yet sent, no limit.
  - else → set the error flag and go to END.
- BUSY_REQ/BUSY_GET: poll 0xFF bytes. Byte 0x00 returns to BUSY_REQ; any nonzero byte goes to END. Polling is unbounded.
- END: one cycle. oCMD_END = 1 and oCMD_ERROR = error flag. Then go to IDLE and clear the error flag.
- iMMC_VALID is ignored outside the *_GET states. Returned bytes from transmitted bytes are discarded.
- oMMC_REQ = !iMMC_BUSY in CMD, RESP_REQ, GAP, TOKEN, SEND, CRC, DRESP_REQ and BUSY_REQ; 0 elsewhere.
- oMMC_DATA is the byte defined by the current state, and 0xFF in every state that defines no byte.
- oMMC_CS = 1 in IDLE and END, 0 elsewhere.
- Illegal state codes → IDLE.

## Timing
- Reset values (iRESET or iRESET_SYNC): state IDLE, counters 0, address 0, word register 0, error 0. Outputs: oCMD_END 0, oCMD_ERROR 0, oBUFF_REQ 0, oBUFF_ADDR 0, oMMC_REQ 0, oMMC_CS 1, oMMC_DATA 0xFF.
- Reset mid-transfer aborts immediately: CS goes high the next cycle and oCMD_END is not pulsed.
- iCMD_START outside IDLE is ignored.
- Each word costs 2 cycles of buffer access (FETCH, LATCH) plus 4 byte accepts. oBUFF_REQ pulses exactly 128 times per successful command, with addresses 0..127 in order.
- With iMMC_BUSY = 0 between requests and no transport latency, a SEND byte is accepted in the state's first cycle.
- Byte-accept order per command: 6 command bytes, at least 1 R1 poll, gap, token, 512 data bytes, 2 CRC bytes, at least 1 response poll, at least 1 busy poll.
- oCMD_END is asserted the cycle after the last deciding iMMC_VALID.

## Test plan
- Normal write, addr 0x00001200, buffer word k = {4{k[7:0]}}, R1 0x00 on the first poll, response 0xE5, busy 0x00×3 then 0xFF:
  - sent bytes: 58 00 00 12 00 01, FF, FF, FE, 512 data bytes with bytes 4k..4k+3 = k, FF FF;
  - oCMD_END with oCMD_ERROR = 0; 128 buffer reads.
- R1 returns 0xFF×3 then 0x00: exactly 4 R1 polls, then normal completion.
- R1 always 0x01: after 8 polls, oCMD_END = 1 and oCMD_ERROR = 1, with no 0xFE sent.
- Data response 0x0B (CRC error): oCMD_END with oCMD_ERROR = 1, and no busy polling.
- Random iMMC_BUSY stalls of 0–5 cycles: byte stream identical to the first scenario, and oMMC_REQ is never high while busy.
- iRESET asserted at data byte 200:
  - next cycle: oMMC_CS = 1, oMMC_REQ = 0, no oCMD_END;
  - a following start runs cleanly from byte 0.
